// File: rtl/memory_unpack.sv
// Serial packet receiver: hunts for a 32-bit preamble, collects a fixed-size payload
// into one of two ping-pong byte banks and streams completed packets out over valid/ready.
module memory_unpack #(
  parameter int unsigned SIZE_BIT_PACK      = 1976,
  parameter int unsigned SIZE_OUTPUT_BIT    = 8,
  parameter int unsigned LENGTHE_OUTPUT_BIT = SIZE_BIT_PACK / SIZE_OUTPUT_BIT,
  parameter int unsigned SIZE_ADDR_OUTPUT   = $clog2(LENGTHE_OUTPUT_BIT),
  parameter int unsigned SISE_PREAMBLE      = 32,
  parameter logic [SISE_PREAMBLE-1:0] PREAMBLE = 32'h1ACFFC1D
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_valid,
  input  logic                       i_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [SIZE_OUTPUT_BIT-1:0] o_data,
  output logic                       o_last,
  output logic                       o_lock,
  output logic                       o_overflow
);

  localparam int unsigned SUB_W = $clog2(SIZE_OUTPUT_BIT);
  localparam int unsigned BIT_W = SIZE_ADDR_OUTPUT + SUB_W;
  localparam logic [BIT_W-1:0]            LAST_BIT  = BIT_W'(SIZE_BIT_PACK - 1);
  localparam logic [SIZE_ADDR_OUTPUT-1:0] LAST_ADDR = SIZE_ADDR_OUTPUT'(LENGTHE_OUTPUT_BIT - 1);

  typedef enum logic {SEARCH, COLLECT} state_t;

  state_t                      state;
  logic [SISE_PREAMBLE-1:0]    sreg;
  logic [SISE_PREAMBLE-1:0]    sreg_next;
  logic [BIT_W-1:0]            bitcnt;
  logic [SIZE_OUTPUT_BIT-1:0]  byte_sh;
  logic [SIZE_OUTPUT_BIT-1:0]  byte_next;
  logic                        wr_bank;
  logic [1:0]                  fill_packs;

  logic                        collect_bit;
  logic                        byte_we;
  logic [SIZE_ADDR_OUTPUT-1:0] wr_addr;
  logic                        set_full;
  logic                        clr_full;
  logic [1:0]                  set_vec;
  logic [1:0]                  clr_vec;

  logic [SIZE_OUTPUT_BIT-1:0]  mem0 [LENGTHE_OUTPUT_BIT];
  logic [SIZE_OUTPUT_BIT-1:0]  mem1 [LENGTHE_OUTPUT_BIT];
  logic [SIZE_OUTPUT_BIT-1:0]  ram_q;

  logic                        iss_bank;
  logic [SIZE_ADDR_OUTPUT-1:0] iss_addr;
  logic                        rd_bank;
  logic                        pend;
  logic                        pend_last;
  logic                        pf_valid;
  logic [SIZE_OUTPUT_BIT-1:0]  pf_data;
  logic                        pf_last;

  logic                        pop;
  logic                        out_free;
  logic                        issue;
  logic                        iss_last;
  logic [1:0]                  occ;

  // Write-side decode
  always_comb begin
    sreg_next   = {sreg[SISE_PREAMBLE-2:0], i_data};
    byte_next   = {byte_sh[SIZE_OUTPUT_BIT-2:0], i_data};
    collect_bit = (state == COLLECT) && i_valid;
    byte_we     = collect_bit && (&bitcnt[SUB_W-1:0]);
    wr_addr     = bitcnt[BIT_W-1:SUB_W];
    set_full    = collect_bit && (bitcnt == LAST_BIT);
    set_vec     = 2'b00;
    if (set_full) set_vec = wr_bank ? 2'b10 : 2'b01;
  end

  // Receive FSM: preamble hunt, then payload collection
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= SEARCH;
      sreg       <= '0;
      bitcnt     <= '0;
      byte_sh    <= '0;
      wr_bank    <= 1'b0;
      o_lock     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_overflow <= 1'b0;
      case (state)
        SEARCH: begin
          if (i_valid) begin
            if (sreg_next == PREAMBLE) begin
              sreg <= '0;
              if (!fill_packs[wr_bank]) begin
                state  <= COLLECT;
                o_lock <= 1'b1;
                bitcnt <= '0;
              end else begin
                o_overflow <= 1'b1;
              end
            end else begin
              sreg <= sreg_next;
            end
          end
        end
        COLLECT: begin
          if (i_valid) begin
            byte_sh <= byte_next;
            if (bitcnt == LAST_BIT) begin
              state   <= SEARCH;
              o_lock  <= 1'b0;
              wr_bank <= ~wr_bank;
              bitcnt  <= '0;
              sreg    <= '0;
            end else begin
              bitcnt <= bitcnt + BIT_W'(1);
            end
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

  // Bank storage with one-cycle synchronous read
  always_ff @(posedge i_clk) begin
    if (byte_we && !wr_bank) mem0[wr_addr] <= byte_next;
    if (byte_we && wr_bank)  mem1[wr_addr] <= byte_next;
    if (issue) ram_q <= iss_bank ? mem1[iss_addr] : mem0[iss_addr];
  end

  // Bank full flags: write side sets, last-byte transfer clears
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) fill_packs <= 2'b00;
    else            fill_packs <= (fill_packs | set_vec) & ~clr_vec;
  end

  // Read-side decode; occ counts bytes held after this cycle's transfer
  always_comb begin
    pop      = o_valid && i_ready;
    out_free = !o_valid || pop;
    clr_full = pop && o_last;
    clr_vec  = 2'b00;
    if (clr_full) clr_vec = rd_bank ? 2'b10 : 2'b01;
    occ      = 2'(o_valid) + 2'(pf_valid) + 2'(pend) - 2'(pop);
    iss_last = (iss_addr == LAST_ADDR);
    issue    = fill_packs[iss_bank] && (occ < 2'd2);
  end

  // Readout pipeline: RAM read -> prefetch slot -> output register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      iss_bank  <= 1'b0;
      iss_addr  <= '0;
      rd_bank   <= 1'b0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      pf_valid  <= 1'b0;
      pf_data   <= '0;
      pf_last   <= 1'b0;
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_last    <= 1'b0;
    end else begin
      pend      <= issue;
      pend_last <= iss_last;
      if (issue) begin
        if (iss_last) begin
          iss_addr <= '0;
          iss_bank <= ~iss_bank;
        end else begin
          iss_addr <= iss_addr + SIZE_ADDR_OUTPUT'(1);
        end
      end
      if (clr_full) rd_bank <= ~rd_bank;
      if (out_free) begin
        if (pf_valid) begin
          o_valid  <= 1'b1;
          o_data   <= pf_data;
          o_last   <= pf_last;
          pf_valid <= pend;
          if (pend) begin
            pf_data <= ram_q;
            pf_last <= pend_last;
          end
        end else if (pend) begin
          o_valid <= 1'b1;
          o_data  <= ram_q;
          o_last  <= pend_last;
        end else begin
          o_valid <= 1'b0;
          o_last  <= 1'b0;
        end
      end else if (pend) begin
        pf_valid <= 1'b1;
        pf_data  <= ram_q;
        pf_last  <= pend_last;
      end
    end
  end

endmodule

// File: tb/tb_memory_unpack.sv
// Scoreboard bench for memory_unpack: serial packets in, expected bytes queued
// as they are sent and compared as the DUT transfers them.
module tb_memory_unpack;

  localparam int NB = 247;
  localparam int NBITS = 1976;
  localparam logic [31:0] PRE = 32'h1ACFFC1D;

  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_valid = 1'b0;
  logic       i_data = 1'b0;
  logic       i_ready = 1'b0;
  logic       o_valid;
  logic [7:0] o_data;
  logic       o_last;
  logic       o_lock;
  logic       o_overflow;

  always #5 i_clk = ~i_clk;

  memory_unpack dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .i_data(i_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_last(o_last),
    .o_lock(o_lock), .o_overflow(o_overflow)
  );

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q[$];
  int beats = 0, last_beats = 0, lock_bits = 0, ovf_count = 0, gap_count = 0;
  bit in_pkt = 0, prev_stall = 0, saw_lock = 0, saw_valid = 0, saw_overlap = 0;
  int ready_mode = 0;
  bit gaps = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // i_ready pattern: 0 = always high, 1 = 1,0,0,1 repeating, 2 = held low
  always @(posedge i_clk) begin
    #1;
    cyc++;
    case (ready_mode)
      0:       i_ready = 1'b1;
      1:       i_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: i_ready = 1'b0;
    endcase
  end

  always @(negedge i_clk) begin
    if (!i_reset_n) begin
      prev_stall = 0;
      in_pkt = 0;
    end else begin
      if (o_lock) saw_lock = 1;
      if (o_valid) saw_valid = 1;
      if (o_lock && o_valid) saw_overlap = 1;
      if (o_lock && i_valid) lock_bits++;
      if (o_overflow) ovf_count++;
      if (prev_stall) check("hold_valid", 32'(o_valid), 32'd1);
      if (in_pkt && i_ready && !o_valid) gap_count++;
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 32'(o_valid), 32'd0);
        end else begin
          check("byte_data", 32'(o_data), 32'(exp_q[0][7:0]));
          check("byte_last", 32'(o_last), 32'(exp_q[0][8]));
          if (i_ready) begin
            void'(exp_q.pop_front());
            beats++;
            if (o_last) last_beats++;
            in_pkt = !o_last;
          end
        end
      end
      prev_stall = o_valid && !i_ready;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    if (gaps && ($urandom_range(0, 3) == 0)) begin
      i_valid = 1'b0;
      tick();
    end
    i_valid = 1'b1;
    i_data  = b;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
  endtask

  // Preamble plus payload byte k = base + k*step; stops before bit stop_bit when >= 0
  task automatic send_packet(input logic [7:0] base, input logic [7:0] step,
                             input bit push, input int stop_bit);
    send_word(PRE);
    for (int k = 0; k < NB; k++) begin
      logic [7:0] b;
      b = base + 8'(k) * step;
      for (int i = 7; i >= 0; i--) begin
        if (k * 8 + (7 - i) == stop_bit) return;
        send_bit(b[i]);
      end
      if (push) exp_q.push_back({(k == NB - 1), b});
    end
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || o_valid) && n < max_cycles) begin
      @(negedge i_clk);
      #1;
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  task automatic async_reset();
    @(posedge i_clk);
    #3;
    i_reset_n = 1'b0;
    #1;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_last", 32'(o_last), 32'd0);
    check("rst_lock", 32'(o_lock), 32'd0);
    check("rst_overflow", 32'(o_overflow), 32'd0);
    exp_q.delete();
    i_valid = 1'b0;
    tick();
    tick();
    i_reset_n = 1'b1;
    tick();
  endtask

  initial begin
    int b0, l0;
    logic [31:0] sw;
    logic bit_r;

    // reset values
    repeat (3) tick();
    check("init_valid", 32'(o_valid), 32'd0);
    check("init_data", 32'(o_data), 32'd0);
    check("init_last", 32'(o_last), 32'd0);
    check("init_lock", 32'(o_lock), 32'd0);
    check("init_overflow", 32'(o_overflow), 32'd0);
    i_reset_n = 1'b1;
    repeat (2) tick();

    // ramp packet at full throughput
    lock_bits = 0; gap_count = 0; b0 = beats; l0 = last_beats;
    send_packet(8'h00, 8'h01, 1'b1, -1);
    wait_drain(600);
    check("ramp_lock_bits", 32'(lock_bits), 32'(NBITS));
    check("ramp_beats", 32'(beats - b0), 32'(NB));
    check("ramp_lasts", 32'(last_beats - l0), 32'd1);
    check("ramp_gaps", 32'(gap_count), 32'd0);

    // false preamble followed by random bits that never form the pattern
    saw_lock = 0; saw_valid = 0;
    send_word(32'h1ACFFC1C);
    sw = 32'h1ACFFC1C;
    for (int i = 0; i < 200; i++) begin
      bit_r = 1'($urandom_range(0, 1));
      if ({sw[30:0], bit_r} == PRE) bit_r = ~bit_r;
      sw = {sw[30:0], bit_r};
      send_bit(bit_r);
    end
    repeat (5) tick();
    check("false_lock", 32'(saw_lock), 32'd0);
    check("false_valid", 32'(saw_valid), 32'd0);
    lock_bits = 0; b0 = beats;
    send_packet(8'h30, 8'h03, 1'b1, -1);
    wait_drain(600);
    check("after_false_lock_bits", 32'(lock_bits), 32'(NBITS));
    check("after_false_beats", 32'(beats - b0), 32'(NB));

    // backpressure 1,0,0,1 with input gaps
    ready_mode = 1; gaps = 1; gap_count = 0; b0 = beats;
    send_packet(8'h80, 8'h07, 1'b1, -1);
    wait_drain(2000);
    check("bp_beats", 32'(beats - b0), 32'(NB));
    check("bp_gaps", 32'(gap_count), 32'd0);
    gaps = 0;

    // overflow: three packets with the sink stalled, third is dropped
    ready_mode = 2;
    repeat (3) tick();
    ovf_count = 0; lock_bits = 0; b0 = beats; l0 = last_beats;
    send_packet(8'hAA, 8'h00, 1'b1, -1);
    send_packet(8'h55, 8'h00, 1'b1, -1);
    send_packet(8'h0F, 8'h00, 1'b0, -1);
    repeat (5) tick();
    check("ovf_pulses", 32'(ovf_count), 32'd1);
    check("ovf_lock_bits", 32'(lock_bits), 32'(2 * NBITS));
    check("ovf_stalled_beats", 32'(beats - b0), 32'd0);
    ready_mode = 0;
    wait_drain(1200);
    check("ovf_beats", 32'(beats - b0), 32'(2 * NB));
    check("ovf_lasts", 32'(last_beats - l0), 32'd2);

    // ping-pong: back-to-back packets, second written while first drains
    saw_overlap = 0; lock_bits = 0; b0 = beats; l0 = last_beats;
    send_packet(8'h11, 8'h01, 1'b1, -1);
    send_packet(8'hE0, 8'h05, 1'b1, -1);
    wait_drain(1200);
    check("pp_overlap", 32'(saw_overlap), 32'd1);
    check("pp_beats", 32'(beats - b0), 32'(2 * NB));
    check("pp_lasts", 32'(last_beats - l0), 32'd2);

    // reset in the middle of a payload
    send_packet(8'h21, 8'h02, 1'b1, 1000);
    check("lock_before_reset", 32'(o_lock), 32'd1);
    async_reset();
    lock_bits = 0; b0 = beats;
    send_packet(8'h9C, 8'h0B, 1'b1, -1);
    wait_drain(600);
    check("post_rst1_beats", 32'(beats - b0), 32'(NB));
    check("post_rst1_lock_bits", 32'(lock_bits), 32'(NBITS));

    // reset during readout at byte 100
    b0 = beats;
    send_packet(8'h40, 8'h01, 1'b1, -1);
    begin
      int n;
      n = 0;
      while (beats < b0 + 100 && n < 2000) begin
        @(negedge i_clk);
        #1;
        n++;
      end
    end
    check("readout_reached_100", 32'(beats - b0), 32'd100);
    async_reset();
    repeat (5) tick();
    check("post_rst2_idle", 32'(o_valid), 32'd0);
    b0 = beats; l0 = last_beats;
    send_packet(8'h05, 8'h0D, 1'b1, -1);
    wait_drain(600);
    check("post_rst2_beats", 32'(beats - b0), 32'(NB));
    check("post_rst2_lasts", 32'(last_beats - l0), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_unpack.md
Name: memory_unpack

Overview:
- Receive-side counterpart of the transmit packet buffer.
- Accepts the serial 1-bit stream, hunts for the 32-bit preamble, then collects SIZE_BIT_PACK payload bits MSB-first into bytes.
- Stores each packet in one of two ping-pong banks and streams completed packets out as bytes over a valid/ready handshake with a last-byte marker.

Parameters:
- SIZE_BIT_PACK, 1976, payload bits per packet (multiple of 8).
- SIZE_OUTPUT_BIT, 8, output byte width.
- LENGTHE_OUTPUT_BIT, SIZE_BIT_PACK/SIZE_OUTPUT_BIT, bytes per packet (247).
- SIZE_ADDR_OUTPUT, $clog2(LENGTHE_OUTPUT_BIT), byte address width.
- SISE_PREAMBLE, 32, preamble length in bits.
- PREAMBLE, 32'h1ACFFC1D, preamble pattern; bit [SISE_PREAMBLE-1] is received first.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  serial bit strobe.
- i_data  in  1  serial bit.
- o_valid  out  1  output byte valid.
- i_ready  in  1  downstream accepts the byte.
- o_data  out  SIZE_OUTPUT_BIT  output byte.
- o_last  out  1  asserted with the final byte of a packet.
- o_lock  out  1  high while a payload is being collected.
- o_overflow  out  1  one-cycle pulse when a packet is dropped.

Behaviour:
- Reset (i_reset_n=0, async):
  - FSM=SEARCH; preamble shift register, bit counter, byte shifter and bank flags all cleared; write and read bank pointers set to bank 0.
  - Outputs: o_valid=0, o_data=0, o_last=0, o_lock=0, o_overflow=0.
  - Packets in flight are discarded.
- Input sampling: i_data is sampled only when i_valid=1; cycles with i_valid=0 change nothing on the input side.
- SEARCH:
  - Shift register: sreg <= {sreg[30:0], i_data}.
  - A match is declared when the newly shifted value equals PREAMBLE (exact compare, no error tolerance).
  - On a match, if the write bank is free -> COLLECT, o_lock=1 from the next cycle, bit counter=0.
  - On a match, if both banks are full -> o_overflow pulses for 1 cycle, stay in SEARCH, sreg cleared.
- COLLECT:
  - Each valid bit is shifted MSB-first into the byte shifter; the first payload bit becomes o_data[7] of byte 0.
  - On every 8th bit the byte is written to the current bank at address bitcnt/8.
  - After bit SIZE_BIT_PACK-1: bank marked full, write pointer toggles, sreg cleared, FSM -> SEARCH, o_lock=0 next cycle.
  - Preamble detection is disabled during COLLECT.
- Banks:
  - Two LENGTHE_OUTPUT_BIT x 8 inferred RAMs with a 1-cycle synchronous read.
  - Full flags fill_packs[1:0].
- Output side:
  - When the read bank is full, bytes 0..LENGTHE_OUTPUT_BIT-1 are presented in order.
  - o_valid rises at most 2 cycles after the bank becomes full.
  - o_data and o_last are held stable while o_valid=1 and i_ready=0.
  - A byte transfers on o_valid & i_ready. The next byte is presented the following cycle; a prefetch register gives full throughput (one byte per cycle with i_ready held high).
  - o_last=1 only for byte LENGTHE_OUTPUT_BIT-1. Its transfer clears that bank's full flag and toggles the read pointer.
  - If the other bank is already full, its byte 0 follows with no idle cycle beyond the read latency.
- Simultaneous events:
  - If the write-side "set full" and the read-side "clear full" occur in the same cycle on different banks, both take effect.
  - They never target the same bank: the write side waits for a free bank at preamble match.
- Ordering: packets are emitted in reception order. A dropped packet never corrupts a stored one.

Test Plan:
- Preamble + ramp: send 1ACFFC1D then 1976 bits forming bytes 0x00,0x01,...,0xF6 (MSB-first), i_ready=1 -> 247 consecutive o_valid beats with o_data=0x00..0xF6, o_last only on 0xF6, o_lock high for exactly 1976 valid bits.
- False/partial preamble: send 1ACFFC1C followed by random bits that do not contain the pattern -> o_valid stays 0, o_lock stays 0; a later correct preamble locks normally.
- Backpressure: i_ready toggling 1,0,0,1 during readout, plus i_valid gaps on input -> o_data/o_last stable while stalled, byte sequence unchanged, no byte lost or duplicated.
- Overflow: i_ready=0, send 3 complete packets (payload A=0xAA.., B=0x55.., C=0x0F..) -> o_overflow pulses once at the third preamble; after releasing i_ready, exactly packets A then B (494 bytes) are emitted.
- Ping-pong: back-to-back packets with i_ready=1 -> second packet written into bank 1 while bank 0 drains; both packets emitted intact and in order.
- Reset mid-operation: assert i_reset_n=0 at payload bit 1000 and separately during readout byte 100 -> all outputs 0 immediately (asynchronously); after release, a fresh preamble+packet is received correctly with no residual data.
